xadc_drp_arbiter: RTL and testbench

Sequences and shares the XADC DRP port between two requesters: the USB register path (host) and an autonomous poller that periodically reads temperature, VCCINT and VCCAUX into cached registers. It sits between the XADC register block and the `xadc_wiz_0` DRP pins. It guarantees exactly one DRP transaction in flight, and bounds every transaction with a DRDY timeout so a missing DRDY never hangs the USB path.

---
 rtl/xadc_drp_arbiter_pkg.sv | 28 ++
 rtl/xadc_poll_timer.sv | 47 ++++
 rtl/xadc_drp_arbiter.sv | 158 +++++++++++++++
 tb/tb_xadc_drp_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_drp_arbiter_pkg.sv
// Shared definitions for the XADC DRP arbiter: channel addresses, FSM encoding
// and the poll-channel to DRP-address mapping.
package xadc_drp_arbiter_pkg;

    localparam logic [6:0] XADC_ADDR_TEMP   = 7'h00;
    localparam logic [6:0] XADC_ADDR_VCCINT = 7'h01;
    localparam logic [6:0] XADC_ADDR_VCCAUX = 7'h02;

    localparam logic [1:0] CH_TEMP   = 2'd0;
    localparam logic [1:0] CH_VCCINT = 2'd1;
    localparam logic [1:0] CH_VCCAUX = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } drp_state_e;

    function automatic logic [6:0] chan_addr(input logic [1:0] idx);
        case (idx)
            CH_VCCINT: return XADC_ADDR_VCCINT;
            CH_VCCAUX: return XADC_ADDR_VCCAUX;
            default:   return XADC_ADDR_TEMP;
        endcase
    endfunction

endpackage

// File: rtl/xadc_poll_timer.sv
// Poll scheduler: reload down-counter raising poll_pend once per period, and the
// round-robin channel index that only moves on a successful poll read.
module xadc_poll_timer
    import xadc_drp_arbiter_pkg::*;
#(
    parameter int pPOLL_CYCLES = 1000000
) (
    input  logic       clk_usb,
    input  logic       reset_i,
    input  logic       poll_en_i,
    input  logic       grant_i,
    input  logic       done_ok_i,
    output logic       poll_pend_o,
    output logic [1:0] chan_idx_o
);

    localparam int CW = (pPOLL_CYCLES > 2) ? $clog2(pPOLL_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(pPOLL_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          pend_q;
    logic [1:0]    idx_q;
    logic          tick;

    assign tick        = poll_en_i && (cnt_q == '0);
    assign poll_pend_o = pend_q;
    assign chan_idx_o  = idx_q;

    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= RELOAD;
            pend_q <= 1'b0;
            idx_q  <= CH_TEMP;
        end else begin
            if (!poll_en_i || tick) cnt_q <= RELOAD;
            else                    cnt_q <= cnt_q - CW'(1);

            // A tick landing while a request is still pending is dropped.
            if (!poll_en_i)  pend_q <= 1'b0;
            else if (grant_i) pend_q <= 1'b0;
            else if (tick)    pend_q <= 1'b1;

            if (done_ok_i) idx_q <= (idx_q == CH_VCCAUX) ? CH_TEMP : idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/xadc_drp_arbiter.sv
// Shares the XADC DRP port between the USB host path and the sensor poller,
// one transaction in flight, every transaction bounded by a DRDY timeout.
module xadc_drp_arbiter
    import xadc_drp_arbiter_pkg::*;
#(
    parameter int pPOLL_CYCLES = 1000000,
    parameter int pTIMEOUT     = 63
) (
    input  logic        clk_usb,
    input  logic        reset_i,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [6:0]  host_addr,
    input  logic [15:0] host_din,
    output logic        host_ack,
    output logic [15:0] host_dout,
    input  logic        poll_en,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [6:0]  drp_addr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic [15:0] temp_o,
    output logic [15:0] vccint_o,
    output logic [15:0] vccaux_o,
    output logic [15:0] temp_max_o,
    output logic        poll_valid_o,
    output logic        timeout_o,
    input  logic        timeout_clr,
    output logic [1:0]  state_o
);

    localparam int TW = $clog2(pTIMEOUT + 1);

    // Host handshake: host_req is a level held with we/addr/din stable until
    // host_ack; host_ack pulses exactly once per accepted request, on DRDY or timeout.
    drp_state_e    state_q;
    logic          sel_poll_q;
    logic          last_poll_q;
    logic [TW-1:0] wait_cnt_q;
    logic          host_ack_q, den_q, dwe_q, valid_q, timeout_q;
    logic [6:0]    addr_q;
    logic [15:0]   di_q, host_dout_q, temp_q, vccint_q, vccaux_q, tmax_q;

    logic       poll_pend;
    logic [1:0] chan_idx;
    logic       poll_want, grant_poll, grant_host;
    logic       drdy_hit, timed_out, poll_ok;

    assign poll_want  = poll_pend && poll_en;
    assign grant_poll = (state_q == ST_IDLE) && poll_want && (!host_req || !last_poll_q);
    assign grant_host = (state_q == ST_IDLE) && host_req && !grant_poll;
    assign drdy_hit   = (state_q == ST_WAIT) && drp_drdy;
    assign timed_out  = (state_q == ST_WAIT) && !drp_drdy && (wait_cnt_q == TW'(pTIMEOUT - 1));
    assign poll_ok    = drdy_hit && sel_poll_q;

    xadc_poll_timer #(.pPOLL_CYCLES(pPOLL_CYCLES)) u_poll_timer (
        .clk_usb     (clk_usb),
        .reset_i     (reset_i),
        .poll_en_i   (poll_en),
        .grant_i     (grant_poll),
        .done_ok_i   (poll_ok),
        .poll_pend_o (poll_pend),
        .chan_idx_o  (chan_idx)
    );

    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            sel_poll_q  <= 1'b0;
            last_poll_q <= 1'b1;
            wait_cnt_q  <= '0;
            host_ack_q  <= 1'b0;
            host_dout_q <= '0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            addr_q      <= '0;
            di_q        <= '0;
            temp_q      <= '0;
            vccint_q    <= '0;
            vccaux_q    <= '0;
            tmax_q      <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            host_ack_q <= 1'b0;
            den_q      <= 1'b0;

            if (timed_out)        timeout_q <= 1'b1;
            else if (timeout_clr) timeout_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (grant_poll || grant_host) begin
                        state_q     <= ST_ISSUE;
                        den_q       <= 1'b1;
                        sel_poll_q  <= grant_poll;
                        last_poll_q <= grant_poll;
                        wait_cnt_q  <= '0;
                        dwe_q       <= grant_poll ? 1'b0 : host_we;
                        addr_q      <= grant_poll ? chan_addr(chan_idx) : host_addr;
                        di_q        <= grant_poll ? 16'h0000 : host_din;
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (drp_drdy) begin
                        state_q <= ST_DONE;
                        if (!sel_poll_q) begin
                            host_ack_q <= 1'b1;
                            if (!dwe_q) host_dout_q <= drp_do;
                        end else begin
                            case (chan_idx)
                                CH_TEMP: begin
                                    temp_q <= drp_do;
                                    if (drp_do > tmax_q) tmax_q <= drp_do;
                                end
                                CH_VCCINT: vccint_q <= drp_do;
                                default: begin
                                    vccaux_q <= drp_do;
                                    valid_q  <= 1'b1;
                                end
                            endcase
                        end
                    end else if (timed_out) begin
                        state_q <= ST_DONE;
                        if (!sel_poll_q) begin
                            host_ack_q  <= 1'b1;
                            host_dout_q <= 16'hFFFF;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    dwe_q   <= 1'b0;
                end
            endcase
        end
    end

    assign host_ack     = host_ack_q;
    assign host_dout    = host_dout_q;
    assign drp_den      = den_q;
    assign drp_dwe      = dwe_q;
    assign drp_addr     = addr_q;
    assign drp_di       = di_q;
    assign temp_o       = temp_q;
    assign vccint_o     = vccint_q;
    assign vccaux_o     = vccaux_q;
    assign temp_max_o   = tmax_q;
    assign poll_valid_o = valid_q;
    assign timeout_o    = timeout_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Directed bench for xadc_drp_arbiter: host reads/writes, poll sweeps, timeouts,
// round-robin ties and reset during a transaction, against a behavioural XADC.
module tb_xadc_drp_arbiter;

    logic        clk_usb, reset_i;
    logic        host_req, host_we;
    logic [6:0]  host_addr;
    logic [15:0] host_din;
    logic        host_ack;
    logic [15:0] host_dout;
    logic        poll_en;
    logic        drp_den, drp_dwe;
    logic [6:0]  drp_addr;
    logic [15:0] drp_di, drp_do;
    logic        drp_drdy;
    logic [15:0] temp_o, vccint_o, vccaux_o, temp_max_o;
    logic        poll_valid_o, timeout_o, timeout_clr;
    logic [1:0]  state_o;

    int vec = 0;
    int miss = 0;
    int cyc = 0;

    bit          model_on;
    int          model_delay;
    int          drdy_pulses = 0;
    logic [15:0] mem [0:127];

    xadc_drp_arbiter #(.pPOLL_CYCLES(16), .pTIMEOUT(8)) dut (
        .clk_usb      (clk_usb),
        .reset_i      (reset_i),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_din     (host_din),
        .host_ack     (host_ack),
        .host_dout    (host_dout),
        .poll_en      (poll_en),
        .drp_den      (drp_den),
        .drp_dwe      (drp_dwe),
        .drp_addr     (drp_addr),
        .drp_di       (drp_di),
        .drp_do       (drp_do),
        .drp_drdy     (drp_drdy),
        .temp_o       (temp_o),
        .vccint_o     (vccint_o),
        .vccaux_o     (vccaux_o),
        .temp_max_o   (temp_max_o),
        .poll_valid_o (poll_valid_o),
        .timeout_o    (timeout_o),
        .timeout_clr  (timeout_clr),
        .state_o      (state_o)
    );

    // Clock / reset block.
    initial begin
        clk_usb = 1'b0;
        forever #5 clk_usb = ~clk_usb;
    end

    initial begin
        forever begin
            @(posedge clk_usb);
            cyc = cyc + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Behavioural XADC: DRDY model_delay cycles after the DEN cycle.
    initial begin
        logic [6:0]  a;
        logic        w;
        logic [15:0] d;
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        forever begin
            @(negedge clk_usb);
            if (drp_den && model_on) begin
                a = drp_addr;
                w = drp_dwe;
                d = drp_di;
                repeat (model_delay) @(negedge clk_usb);
                drp_drdy = 1'b1;
                drdy_pulses = drdy_pulses + 1;
                if (w) mem[a] = d;
                else   drp_do = mem[a];
                @(negedge clk_usb);
                drp_drdy = 1'b0;
            end
        end
    end

    // Driver: one host transaction; cycle 0 is the cycle host_req is first seen.
    task automatic host_xfer(input logic we, input logic [6:0] addr, input logic [15:0] din,
                             input int clr_at, output logic [15:0] dout, output int lat,
                             output int den_cnt, output logic [6:0] c_addr, output logic c_dwe,
                             output logic [15:0] c_di, output bit stable);
        int t0;
        bit got, seen;
        @(negedge clk_usb);
        host_we = we; host_addr = addr; host_din = din; host_req = 1'b1;
        t0 = cyc; lat = -1; den_cnt = 0; stable = 1'b1; seen = 1'b0; got = 1'b0;
        dout = 16'h0000; c_addr = 7'h00; c_dwe = 1'b0; c_di = 16'h0000;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk_usb);
            timeout_clr = (n == clr_at);
            if (drp_den) begin
                den_cnt++;
                if (!seen) begin c_addr = drp_addr; c_dwe = drp_dwe; c_di = drp_di; end
                seen = 1'b1;
            end else if (seen && !host_ack) begin
                if (drp_addr !== c_addr || drp_dwe !== c_dwe || drp_di !== c_di) stable = 1'b0;
            end
            if (host_ack) begin
                got = 1'b1; lat = cyc - t0; dout = host_dout; host_req = 1'b0;
            end
        end
        host_req = 1'b0;
        timeout_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(negedge clk_usb);
        reset_i = 1'b0;
        @(negedge clk_usb);
        vec++; if ({host_ack, drp_den, drp_dwe, poll_valid_o, timeout_o} !== 5'b0) begin miss++; $display("FAIL reset_flags: got %b, want 00000", {host_ack, drp_den, drp_dwe, poll_valid_o, timeout_o}); end
        vec++; if (host_dout !== 16'h0000) begin miss++; $display("FAIL reset_host_dout: got %h, want 0000", host_dout); end
        vec++; if ({drp_addr, drp_di} !== 23'h0) begin miss++; $display("FAIL reset_drp_bus: got %h/%h, want 00/0000", drp_addr, drp_di); end
        vec++; if ({temp_o, vccint_o, vccaux_o, temp_max_o} !== 64'h0) begin miss++; $display("FAIL reset_cache: got %h, want 0", {temp_o, vccint_o, vccaux_o, temp_max_o}); end
        vec++; if (state_o !== 2'd0) begin miss++; $display("FAIL reset_state: got %0d, want 0", state_o); end
    endtask

    task automatic test_host_read();
        logic [15:0] d, cd; logic [6:0] ca; logic cw; int lat, dc; bit st;
        mem[7'h00] = 16'h9A3C; model_delay = 3; model_on = 1'b1;
        host_xfer(1'b0, 7'h00, 16'h0000, -1, d, lat, dc, ca, cw, cd, st);
        vec++; if (lat !== 5) begin miss++; $display("FAIL read_latency: got %0d, want 5", lat); end
        vec++; if (d !== 16'h9A3C) begin miss++; $display("FAIL read_data: got %h, want 9a3c", d); end
        vec++; if (dc !== 1) begin miss++; $display("FAIL read_den_cycles: got %0d, want 1", dc); end
        vec++; if ({cw, ca} !== 8'h00) begin miss++; $display("FAIL read_issue: got dwe=%b addr=%h, want 0/00", cw, ca); end
        @(negedge clk_usb);
        vec++; if ({host_ack, host_dout} !== {1'b0, 16'h9A3C}) begin miss++; $display("FAIL read_hold: got ack=%b dout=%h, want 0/9a3c", host_ack, host_dout); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d, cd; logic [6:0] ca; logic cw; int lat, dc; bit st;
        mem[7'h05] = 16'h1234; mem[7'h06] = 16'h5678; model_delay = 1;
        host_xfer(1'b0, 7'h05, 16'h0000, -1, d, lat, dc, ca, cw, cd, st);
        vec++; if (lat !== 3) begin miss++; $display("FAIL min_latency: got %0d, want 3", lat); end
        vec++; if (d !== 16'h1234) begin miss++; $display("FAIL b2b_data0: got %h, want 1234", d); end
        host_xfer(1'b0, 7'h06, 16'h0000, -1, d, lat, dc, ca, cw, cd, st);
        vec++; if (lat !== 3) begin miss++; $display("FAIL b2b_latency: got %0d, want 3", lat); end
        vec++; if (d !== 16'h5678) begin miss++; $display("FAIL b2b_data1: got %h, want 5678", d); end
    endtask

    task automatic test_host_write();
        logic [15:0] d, cd; logic [6:0] ca; logic cw; int lat, dc; bit st;
        model_delay = 2;
        host_xfer(1'b1, 7'h41, 16'h2000, -1, d, lat, dc, ca, cw, cd, st);
        vec++; if (lat !== 4) begin miss++; $display("FAIL write_latency: got %0d, want 4", lat); end
        vec++; if ({cw, ca, cd} !== {1'b1, 7'h41, 16'h2000}) begin miss++; $display("FAIL write_issue: got dwe=%b addr=%h di=%h, want 1/41/2000", cw, ca, cd); end
        vec++; if (st !== 1'b1) begin miss++; $display("FAIL write_stable: got %b, want 1", st); end
        host_xfer(1'b0, 7'h41, 16'h0000, -1, d, lat, dc, ca, cw, cd, st);
        vec++; if (d !== 16'h2000) begin miss++; $display("FAIL write_readback: got %h, want 2000", d); end
    endtask

    task automatic test_timeout();
        logic [15:0] d, cd; logic [6:0] ca; logic cw; int lat, dc; bit st;
        model_on = 1'b0;
        host_xfer(1'b0, 7'h20, 16'h0000, -1, d, lat, dc, ca, cw, cd, st);
        vec++; if (lat !== 10) begin miss++; $display("FAIL timeout_latency: got %0d, want 10", lat); end
        vec++; if (d !== 16'hFFFF) begin miss++; $display("FAIL timeout_data: got %h, want ffff", d); end
        vec++; if (timeout_o !== 1'b1) begin miss++; $display("FAIL timeout_flag: got %b, want 1", timeout_o); end
        @(negedge clk_usb); timeout_clr = 1'b1;
        @(negedge clk_usb); timeout_clr = 1'b0;
        vec++; if (timeout_o !== 1'b0) begin miss++; $display("FAIL timeout_clear: got %b, want 0", timeout_o); end
        host_xfer(1'b0, 7'h21, 16'h0000, 9, d, lat, dc, ca, cw, cd, st);
        vec++; if (lat !== 10) begin miss++; $display("FAIL timeout2_latency: got %0d, want 10", lat); end
        vec++; if (timeout_o !== 1'b1) begin miss++; $display("FAIL timeout_set_wins: got %b, want 1", timeout_o); end
        model_on = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [15:0] d, cd; logic [6:0] ca; logic cw; int lat, dc; bit st;
        bit found; int acks, dens, p0;
        model_delay = 5; mem[7'h10] = 16'hABCD; found = 1'b0;
        @(negedge clk_usb);
        host_we = 1'b0; host_addr = 7'h10; host_din = 16'h0000; host_req = 1'b1;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk_usb);
            if (state_o === 2'd2) found = 1'b1;
        end
        vec++; if (found !== 1'b1) begin miss++; $display("FAIL mid_reached_wait: got %b, want 1", found); end
        p0 = drdy_pulses;
        reset_i = 1'b1; host_req = 1'b0;
        @(negedge clk_usb);
        reset_i = 1'b0;
        vec++; if ({state_o, host_dout, timeout_o} !== 19'h0) begin miss++; $display("FAIL mid_reset_outputs: got state=%0d dout=%h to=%b, want 0", state_o, host_dout, timeout_o); end
        acks = 0; dens = 0;
        repeat (8) begin
            @(negedge clk_usb);
            if (host_ack) acks++;
            if (drp_den) dens++;
        end
        vec++; if (drdy_pulses - p0 !== 1) begin miss++; $display("FAIL mid_late_drdy: got %0d, want 1", drdy_pulses - p0); end
        vec++; if ({acks, dens} !== 64'h0) begin miss++; $display("FAIL mid_no_ack: got acks=%0d dens=%0d, want 0/0", acks, dens); end
        vec++; if (host_dout !== 16'h0000) begin miss++; $display("FAIL mid_dout_zero: got %h, want 0000", host_dout); end
        model_delay = 2;
        host_xfer(1'b0, 7'h10, 16'h0000, -1, d, lat, dc, ca, cw, cd, st);
        vec++; if ({lat, d} !== {32'd4, 16'hABCD}) begin miss++; $display("FAIL mid_recover: got lat=%0d dout=%h, want 4/abcd", lat, d); end
    endtask

    task automatic test_poll();
        logic [6:0] alog[$];
        bit found;
        mem[7'h00] = 16'h8000; mem[7'h01] = 16'h5555; mem[7'h02] = 16'h9999;
        model_delay = 2; model_on = 1'b1; found = 1'b0;
        @(negedge clk_usb); poll_en = 1'b1;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk_usb);
            if (drp_den) alog.push_back(drp_addr);
            if (poll_valid_o) found = 1'b1;
        end
        vec++; if (found !== 1'b1) begin miss++; $display("FAIL poll_valid_rise: got %b, want 1", found); end
        vec++; if (alog.size() !== 3) begin miss++; $display("FAIL poll_sweep_len: got %0d, want 3", alog.size()); end
        for (int i = 0; i < 3; i++) begin
            vec++;
            if (i >= alog.size() || alog[i] !== 7'(i)) begin miss++; $display("FAIL poll_addr%0d: got %h, want %h", i, (i < alog.size()) ? alog[i] : 7'h7F, 7'(i)); end
        end
        vec++; if ({temp_o, vccint_o, vccaux_o} !== {16'h8000, 16'h5555, 16'h9999}) begin miss++; $display("FAIL poll_cache: got %h/%h/%h, want 8000/5555/9999", temp_o, vccint_o, vccaux_o); end
        vec++; if (temp_max_o !== 16'h8000) begin miss++; $display("FAIL poll_max1: got %h, want 8000", temp_max_o); end
        mem[7'h00] = 16'h7000; found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk_usb);
            if (temp_o === 16'h7000) found = 1'b1;
        end
        vec++; if (temp_o !== 16'h7000) begin miss++; $display("FAIL poll_temp2: got %h, want 7000", temp_o); end
        vec++; if ({temp_max_o, poll_valid_o} !== {16'h8000, 1'b1}) begin miss++; $display("FAIL poll_max2: got %h valid=%b, want 8000/1", temp_max_o, poll_valid_o); end
        poll_en = 1'b0;
        repeat (10) @(negedge clk_usb);
    endtask

    task automatic test_round_robin();
        bit glog[$];
        bit raise;
        model_on = 1'b0; poll_en = 1'b1; raise = 1'b0;
        host_we = 1'b0; host_addr = 7'h33; host_din = 16'h0000; host_req = 1'b0;
        @(negedge clk_usb); reset_i = 1'b1;
        @(negedge clk_usb); reset_i = 1'b0;
        // Host first seen on the same edge the first poll tick is pending.
        repeat (16) @(posedge clk_usb);
        @(negedge clk_usb); host_req = 1'b1;
        for (int n = 0; n < 400 && glog.size() < 6; n++) begin
            @(negedge clk_usb);
            if (drp_den) glog.push_back(drp_addr !== 7'h33);
            if (raise) begin host_req = 1'b1; raise = 1'b0; end
            if (host_ack) begin host_req = 1'b0; raise = 1'b1; end
        end
        host_req = 1'b0; poll_en = 1'b0;
        vec++; if (glog.size() !== 6) begin miss++; $display("FAIL rr_grant_count: got %0d, want 6", glog.size()); end
        for (int i = 0; i < glog.size(); i++) begin
            vec++;
            if (glog[i] !== 1'(i % 2)) begin miss++; $display("FAIL rr_grant%0d: got poll=%b, want %b", i, glog[i], 1'(i % 2)); end
        end
        repeat (15) @(negedge clk_usb);
        timeout_clr = 1'b1;
        @(negedge clk_usb); timeout_clr = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = 7'h00; host_din = 16'h0000;
        poll_en = 1'b0; timeout_clr = 1'b0; model_on = 1'b1; model_delay = 3;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        test_reset();
        test_host_read();
        test_back_to_back();
        test_host_write();
        test_timeout();
        test_reset_mid();
        test_poll();
        test_round_robin();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
